exe_stage_mc: RTL
=================

Name: exe_stage_mc

Overview:
Parametrised execute stage for the ARM pipeline. It sits between the ID/EXE and EXE/MEM pipeline registers. It adds to the single-cycle stage:
- an integrated ALU with carry-in from its own NZCV status register;
- branch-target generation;
- a multi-cycle iterative MUL unit that stalls the upstream stages while it runs.

Parameters:
N, 32, datapath width; must be a multiple of K.
K, 4, multiplier bits retired per cycle; a MUL takes N/K busy cycles.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
validIn  in  1  instruction in stage is real (not a bubble).
flushIn  in  1  kill the current instruction, including an in-flight MUL.
EXE_CMDIn  in  4  MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010.
SIn  in  1  update status flags.
WB_ENIn, MEM_R_ENIn, MEM_W_ENIn  in  1 each  control passed toward MEM.
Val1In  in  N  first operand (Rn).
Val2In  in  N  second operand (shifter output).
Val_RmIn  in  N  store data.
Imm24In  in  24  branch offset.
PCIn  in  N  PC+4 of the instruction.
ALU_ResOut  out  N  result.
StatusOut  out  4  NZCV, bit 3 = N.
Br_AddrOut  out  N  branch target.
PCOut  out  N  PCIn passthrough.
Val_RmOut  out  N  Val_RmIn passthrough.
WB_ENOut, MEM_R_ENOut, MEM_W_ENOut  out  1 each  gated control.
validOut  out  1  result valid for EXE/MEM.
stallOut  out  1  freeze PC, IF/ID and ID/EXE.

Behaviour:
- Reset: rst high forces asynchronously:
  - FSM to IDLE; counter, accumulator and StatusOut to 0;
  - stallOut = 0, validOut = 0.
  - Reset mid-MUL abandons the MUL with no status update.
- Combinational paths:
  - Br_AddrOut = PCIn + (sign-extended Imm24In << 2), mod 2^N.
  - PCOut = PCIn; Val_RmOut = Val_RmIn.
- Single-cycle ops (all except MUL):
  - Result is combinational.
  - ADC = Val1 + Val2 + C.
  - SBC = Val1 − Val2 − (1 − C).
  - MVN = ~Val2.
  - All arithmetic is mod 2^N.
- Flags:
  - N = res[N−1].
  - Z = (res == 0).
  - ADD/ADC: C = carry out of bit N−1; V = signed overflow.
  - SUB/SBC: C = NOT borrow; V = signed overflow.
  - Logical ops, MOV/MVN and MUL: C and V are preserved.
- Status register:
  - Updates on the falling clk edge when SIn & validOut & ~stallOut.
  - Otherwise it holds.
- validOut: validIn & ~flushIn & ~stallOut.
- Control gating: WB_ENOut, MEM_R_ENOut and MEM_W_ENOut are the corresponding inputs ANDed with validOut.
- MUL FSM states: IDLE, BUSY, DONE.
  - IDLE, when validIn & ~flushIn & cmd == MUL:
    - stallOut = 1 combinationally in the same cycle.
    - At posedge: latch multiplicand = Val1, multiplier = Val2, acc = 0, cnt = 0; go to BUSY.
  - BUSY, each cycle:
    - acc += multiplicand × multiplier[K−1:0], keeping the low N bits;
    - multiplicand <<= K; multiplier >>= K; cnt++;
    - stallOut = 1.
    - When cnt reaches N/K − 1 in BUSY, go to DONE.
  - DONE:
    - stallOut = 0; ALU_ResOut = acc; validOut follows the rule above.
    - Status updates on the falling edge if SIn.
    - Return to IDLE at the next posedge. The still-present MUL in validIn is not re-issued.
  - MUL latency: stallOut is high for N/K + 1 cycles (default 9); the result appears in the following cycle.
  - Upstream holds all inputs stable while stallOut = 1. Changes to inputs are ignored because operands are latched.
- Flush:
  - flushIn in any state → IDLE at the next posedge.
  - stallOut drops combinationally in that cycle.
  - No status update, validOut = 0.
  - flushIn with a MUL issue in IDLE: the MUL is not started.
- While stallOut = 1: ALU_ResOut is don't-care, but all enables are 0.
- Only the low N bits of the product are produced. Operands are treated as unsigned; this equals the signed low product.

Test Plan:
1. Reset mid-MUL: rst pulsed asynchronously in BUSY cycle 4 → immediately StatusOut = 0000, stallOut = 0, validOut = 0. The next ADD 2+3 gives 5.
2. ADDS 0x7FFFFFFF + 0x00000001, SIn = 1 → ALU_ResOut = 0x80000000; after the falling edge NZCV = 1001.
3. SUBS 5 − 5 → 0, NZCV = 0110. Then ADC 1 + 1, SIn = 0 → 3, flags unchanged. Then ANDS 0xF0 & 0x0F → 0, NZCV = 0110 (C preserved).
4. MUL 0x00010003 × 0x00000007, SIn = 1, K = 4:
   - stallOut high for 9 cycles; WB_ENOut = 0 throughout.
   - 10th cycle: ALU_ResOut = 0x00070015, validOut = 1, NZCV = 00CV with prior C,V kept.
5. MUL with flushIn in BUSY cycle 3 → next cycle state IDLE, stallOut = 0, validOut = 0, StatusOut unchanged.
6. PCIn = 0x00000100, Imm24In = 0xFFFFFE → Br_AddrOut = 0x000000F8. PCIn = 0x10, Imm24In = 0x000004 → 0x20.

Source files
------------

// File: rtl/exe_stage_mc_if.sv
// Execute-stage bundle: upstream (ID/EXE side) drives the *In signals, the stage drives the *Out
// signals. Handshake: validOut marks a real result; stallOut freezes the upstream stages, which
// must hold every input stable until it drops.
interface exe_stage_mc_if #(parameter int N = 32);
  logic         validIn;
  logic         flushIn;
  logic [3:0]   EXE_CMDIn;
  logic         SIn;
  logic         WB_ENIn;
  logic         MEM_R_ENIn;
  logic         MEM_W_ENIn;
  logic [N-1:0] Val1In;
  logic [N-1:0] Val2In;
  logic [N-1:0] Val_RmIn;
  logic [23:0]  Imm24In;
  logic [N-1:0] PCIn;

  logic [N-1:0] ALU_ResOut;
  logic [3:0]   StatusOut;
  logic [N-1:0] Br_AddrOut;
  logic [N-1:0] PCOut;
  logic [N-1:0] Val_RmOut;
  logic         WB_ENOut;
  logic         MEM_R_ENOut;
  logic         MEM_W_ENOut;
  logic         validOut;
  logic         stallOut;
  logic [1:0]   dbg_state;

  modport master (
    output validIn, flushIn, EXE_CMDIn, SIn, WB_ENIn, MEM_R_ENIn, MEM_W_ENIn,
           Val1In, Val2In, Val_RmIn, Imm24In, PCIn,
    input  ALU_ResOut, StatusOut, Br_AddrOut, PCOut, Val_RmOut,
           WB_ENOut, MEM_R_ENOut, MEM_W_ENOut, validOut, stallOut, dbg_state
  );

  modport slave (
    input  validIn, flushIn, EXE_CMDIn, SIn, WB_ENIn, MEM_R_ENIn, MEM_W_ENIn,
           Val1In, Val2In, Val_RmIn, Imm24In, PCIn,
    output ALU_ResOut, StatusOut, Br_AddrOut, PCOut, Val_RmOut,
           WB_ENOut, MEM_R_ENOut, MEM_W_ENOut, validOut, stallOut, dbg_state
  );
endinterface

// File: rtl/exe_stage_mc.sv
// ARM execute stage: single-cycle ALU with NZCV register, branch-target adder and an
// iterative K-bits-per-cycle multiplier that stalls upstream while it runs.
module exe_stage_mc #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic            clk,
  input  logic            rst,
  exe_stage_mc_if.slave   bus
);
  localparam int STEPS = N / K;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_acc, r_mcand, r_mplier;
  logic [3:0]      r_status;

  logic            w_issue, w_stall, w_load, w_step, w_valid;
  logic            w_arith, w_cin;
  logic [N-1:0]    w_b_eff, w_res;
  logic [N:0]      w_sum;
  logic            w_ovf;
  logic [3:0]      w_flags;

  assign w_issue = bus.validIn & ~bus.flushIn & (bus.EXE_CMDIn == CMD_MUL);

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_load  = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      S_IDLE: if (w_issue) begin
        w_stall = 1'b1;
        w_load  = 1'b1;
        w_next  = S_BUSY;
      end
      S_BUSY: if (bus.flushIn) begin
        w_next = S_IDLE;
      end else begin
        w_stall = 1'b1;
        w_step  = 1'b1;
        if (r_cnt == CW'(STEPS - 1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Reset must release the pipeline even while a MUL sits at the stage input.
    if (rst) w_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_mcand  <= bus.Val1In;
        r_mplier <= bus.Val2In;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_step) begin
        r_acc    <= r_acc + r_mcand * N'(r_mplier[K-1:0]);
        r_mcand  <= r_mcand << K;
        r_mplier <= r_mplier >> K;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Subtraction is a + ~b + cin so carry-out is already the ARM "not borrow".
  always_comb begin
    w_arith = 1'b0;
    w_b_eff = bus.Val2In;
    w_cin   = 1'b0;
    case (bus.EXE_CMDIn)
      CMD_ADD: w_arith = 1'b1;
      CMD_ADC: begin w_arith = 1'b1; w_cin = r_status[1]; end
      CMD_SUB: begin w_arith = 1'b1; w_b_eff = ~bus.Val2In; w_cin = 1'b1; end
      CMD_SBC: begin w_arith = 1'b1; w_b_eff = ~bus.Val2In; w_cin = r_status[1]; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, bus.Val1In} + {1'b0, w_b_eff} + (N+1)'(w_cin);
  assign w_ovf = (bus.Val1In[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != bus.Val1In[N-1]);

  always_comb begin
    w_res = '0;
    case (bus.EXE_CMDIn)
      CMD_MOV: w_res = bus.Val2In;
      CMD_MVN: w_res = ~bus.Val2In;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_res = w_sum[N-1:0];
      CMD_AND: w_res = bus.Val1In & bus.Val2In;
      CMD_ORR: w_res = bus.Val1In | bus.Val2In;
      CMD_EOR: w_res = bus.Val1In ^ bus.Val2In;
      CMD_MUL: w_res = r_acc;
      default: w_res = '0;
    endcase
  end

  assign w_flags = {w_res[N-1], (w_res == '0),
                    w_arith ? w_sum[N] : r_status[1],
                    w_arith ? w_ovf    : r_status[0]};

  assign w_valid = bus.validIn & ~bus.flushIn & ~w_stall & ~rst;

  always_ff @(negedge clk or posedge rst) begin
    if (rst)                    r_status <= 4'b0000;
    else if (bus.SIn & w_valid) r_status <= w_flags;
  end

  assign bus.ALU_ResOut  = w_res;
  assign bus.StatusOut   = r_status;
  assign bus.Br_AddrOut  = bus.PCIn + {{(N-26){bus.Imm24In[23]}}, bus.Imm24In, 2'b00};
  assign bus.PCOut       = bus.PCIn;
  assign bus.Val_RmOut   = bus.Val_RmIn;
  assign bus.WB_ENOut    = bus.WB_ENIn    & w_valid;
  assign bus.MEM_R_ENOut = bus.MEM_R_ENIn & w_valid;
  assign bus.MEM_W_ENOut = bus.MEM_W_ENIn & w_valid;
  assign bus.validOut    = w_valid;
  assign bus.stallOut    = w_stall;
  assign bus.dbg_state   = r_state;
endmodule
